// File: rtl/rob_commit_unit_pkg.sv
// Shared reorder-buffer definitions: sizes and the per-entry record.
package rob_commit_unit_pkg;

   localparam int ROB_SIZE     = 18;
   localparam int ROB_IDX_SIZE = $clog2(ROB_SIZE);
   localparam int REG_SIZE     = 64;
   localparam int GPR_IDX_SIZE = 5;

   // Last legal entry index and the "full" occupancy value, pre-sized so
   // comparisons against pointers and the counter stay width-exact.
   localparam logic [ROB_IDX_SIZE-1:0] ROB_LAST = ROB_IDX_SIZE'(ROB_SIZE - 1);
   localparam logic [ROB_IDX_SIZE:0]   ROB_FULL = (ROB_IDX_SIZE + 1)'(ROB_SIZE);

   typedef struct packed {
      logic                    busy;
      logic                    done;
      logic [GPR_IDX_SIZE-1:0] gpr_idx;
      logic [REG_SIZE-1:0]     value;
      logic                    set_nzcv;
      logic [3:0]              nzcv;
   } rob_entry_t;

endpackage

// File: rtl/rob_ptr.sv
// Modulo-DEPTH pointer with increment enable; DEPTH need not be a power of two.
module rob_ptr #(
   parameter int DEPTH = 18,
   parameter int W     = 5
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         inc_i,
   output logic [W-1:0] ptr_o
);

   localparam logic [W-1:0] LAST = W'(DEPTH - 1);

   logic [W-1:0] ptr_q, ptr_d;

   // Next pointer: wrap explicitly at DEPTH-1 instead of relying on overflow.
   always_comb begin
      ptr_d = ptr_q;
      if (inc_i) begin
         ptr_d = (ptr_q == LAST) ? '0 : ptr_q + 1'b1;
      end
   end

   // Pointer register with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) ptr_q <= '0;
      else       ptr_q <= ptr_d;
   end

   assign ptr_o = ptr_q;

endmodule

// File: rtl/rob_commit_unit.sv
// Reorder buffer with in-order single-entry commit and two operand read
// ports. Handshake: an allocation happens on a clock edge where both
// in_alloc_valid and out_alloc_ready are high; commit has no backpressure
// and retires on every edge where out_commit_valid is high.
module rob_commit_unit
   import rob_commit_unit_pkg::*;
(
   input  logic                    in_clk,
   input  logic                    in_rst,
   input  logic                    in_alloc_valid,
   input  logic [GPR_IDX_SIZE-1:0] in_alloc_gpr_idx,
   input  logic                    in_alloc_set_nzcv,
   output logic                    out_alloc_ready,
   output logic [ROB_IDX_SIZE-1:0] out_alloc_index,
   input  logic                    in_wb_valid,
   input  logic [ROB_IDX_SIZE-1:0] in_wb_rob_index,
   input  logic [REG_SIZE-1:0]     in_wb_value,
   input  logic [3:0]              in_wb_nzcv,
   input  logic [ROB_IDX_SIZE-1:0] in_rd1_index,
   input  logic [ROB_IDX_SIZE-1:0] in_rd2_index,
   output logic                    out_rd1_ready,
   output logic                    out_rd2_ready,
   output logic [REG_SIZE-1:0]     out_rd1_value,
   output logic [REG_SIZE-1:0]     out_rd2_value,
   output logic                    out_commit_valid,
   output logic [GPR_IDX_SIZE-1:0] out_commit_gpr_idx,
   output logic [REG_SIZE-1:0]     out_commit_value,
   output logic                    out_commit_set_nzcv,
   output logic [3:0]              out_commit_nzcv,
   output logic [ROB_IDX_SIZE-1:0] out_commit_rob_index,
   output logic [ROB_IDX_SIZE:0]   out_count,
   output logic                    out_wb_err
);

   rob_entry_t rob_q [ROB_SIZE];

   logic [ROB_IDX_SIZE-1:0] head_q, tail_q;
   logic [ROB_IDX_SIZE:0]   count_q, count_d;
   logic                    wb_err_q, wb_err_d;
   logic                    alloc_fire, commit_fire, wb_ok;
   logic                    wb_in_range, rd1_in_range, rd2_in_range;
   logic                    rd1_fwd, rd2_fwd;

   rob_ptr #(.DEPTH(ROB_SIZE), .W(ROB_IDX_SIZE)) u_head (
      .clk_i (in_clk),
      .rst_i (in_rst),
      .inc_i (commit_fire),
      .ptr_o (head_q)
   );

   rob_ptr #(.DEPTH(ROB_SIZE), .W(ROB_IDX_SIZE)) u_tail (
      .clk_i (in_clk),
      .rst_i (in_rst),
      .inc_i (alloc_fire),
      .ptr_o (tail_q)
   );

   // Allocation, writeback acceptance, commit and occupancy next-state.
   // Indices above ROB_SIZE-1 never name a real entry and are treated as free.
   always_comb begin
      out_alloc_ready  = (count_q != ROB_FULL);
      out_alloc_index  = tail_q;
      alloc_fire       = in_alloc_valid && out_alloc_ready;

      out_commit_valid = (count_q != '0) && rob_q[head_q].busy && rob_q[head_q].done;
      commit_fire      = out_commit_valid;

      wb_in_range = (in_wb_rob_index <= ROB_LAST);
      wb_ok       = in_wb_valid && wb_in_range &&
                    rob_q[in_wb_rob_index].busy && !rob_q[in_wb_rob_index].done;
      wb_err_d    = wb_err_q || (in_wb_valid && !wb_ok);

      count_d = count_q;
      case ({alloc_fire, commit_fire})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Operand read ports with same-cycle CDB forwarding; zero when not ready.
   always_comb begin
      rd1_in_range  = (in_rd1_index <= ROB_LAST);
      rd2_in_range  = (in_rd2_index <= ROB_LAST);
      rd1_fwd       = rd1_in_range && in_wb_valid && (in_wb_rob_index == in_rd1_index) &&
                      rob_q[in_rd1_index].busy;
      rd2_fwd       = rd2_in_range && in_wb_valid && (in_wb_rob_index == in_rd2_index) &&
                      rob_q[in_rd2_index].busy;
      out_rd1_ready = rd1_fwd ||
                      (rd1_in_range && rob_q[in_rd1_index].busy && rob_q[in_rd1_index].done);
      out_rd2_ready = rd2_fwd ||
                      (rd2_in_range && rob_q[in_rd2_index].busy && rob_q[in_rd2_index].done);
      out_rd1_value = '0;
      out_rd2_value = '0;
      if (rd1_fwd)            out_rd1_value = in_wb_value;
      else if (out_rd1_ready) out_rd1_value = rob_q[in_rd1_index].value;
      if (rd2_fwd)            out_rd2_value = in_wb_value;
      else if (out_rd2_ready) out_rd2_value = rob_q[in_rd2_index].value;
   end

   // Entry storage, occupancy and sticky error. Allocate (tail, free entry),
   // writeback (busy, not done) and commit (head, done) never hit the same
   // entry field in one cycle, so their order here does not matter.
   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         for (int i = 0; i < ROB_SIZE; i++) begin
            rob_q[i] <= '0;
         end
         count_q  <= '0;
         wb_err_q <= 1'b0;
      end else begin
         if (alloc_fire) begin
            rob_q[tail_q].busy     <= 1'b1;
            rob_q[tail_q].done     <= 1'b0;
            rob_q[tail_q].gpr_idx  <= in_alloc_gpr_idx;
            rob_q[tail_q].set_nzcv <= in_alloc_set_nzcv;
         end
         if (wb_ok) begin
            rob_q[in_wb_rob_index].value <= in_wb_value;
            rob_q[in_wb_rob_index].nzcv  <= in_wb_nzcv;
            rob_q[in_wb_rob_index].done  <= 1'b1;
         end
         if (commit_fire) begin
            rob_q[head_q].busy <= 1'b0;
            rob_q[head_q].done <= 1'b0;
         end
         count_q  <= count_d;
         wb_err_q <= wb_err_d;
      end
   end

   assign out_commit_gpr_idx   = rob_q[head_q].gpr_idx;
   assign out_commit_value     = rob_q[head_q].value;
   assign out_commit_set_nzcv  = rob_q[head_q].set_nzcv;
   assign out_commit_nzcv      = rob_q[head_q].nzcv;
   assign out_commit_rob_index = head_q;
   assign out_count            = count_q;
   assign out_wb_err           = wb_err_q;

endmodule

// File: tb/tb_rob_commit_unit.sv
// Directed bench for rob_commit_unit: commits are checked by a monitor
// against an expected queue; status outputs are checked inline.
module tb_rob_commit_unit;
   import rob_commit_unit_pkg::*;

   localparam int CW = GPR_IDX_SIZE + REG_SIZE + 1 + 4 + ROB_IDX_SIZE;

   logic                    in_clk = 1'b0;
   logic                    in_rst;
   logic                    in_alloc_valid;
   logic [GPR_IDX_SIZE-1:0] in_alloc_gpr_idx;
   logic                    in_alloc_set_nzcv;
   logic                    out_alloc_ready;
   logic [ROB_IDX_SIZE-1:0] out_alloc_index;
   logic                    in_wb_valid;
   logic [ROB_IDX_SIZE-1:0] in_wb_rob_index;
   logic [REG_SIZE-1:0]     in_wb_value;
   logic [3:0]              in_wb_nzcv;
   logic [ROB_IDX_SIZE-1:0] in_rd1_index, in_rd2_index;
   logic                    out_rd1_ready, out_rd2_ready;
   logic [REG_SIZE-1:0]     out_rd1_value, out_rd2_value;
   logic                    out_commit_valid;
   logic [GPR_IDX_SIZE-1:0] out_commit_gpr_idx;
   logic [REG_SIZE-1:0]     out_commit_value;
   logic                    out_commit_set_nzcv;
   logic [3:0]              out_commit_nzcv;
   logic [ROB_IDX_SIZE-1:0] out_commit_rob_index;
   logic [ROB_IDX_SIZE:0]   out_count;
   logic                    out_wb_err;

   logic [CW-1:0] exp_q[$];
   int vectors     = 0;
   int miscompares = 0;

   rob_commit_unit dut (
      .in_clk               (in_clk),
      .in_rst               (in_rst),
      .in_alloc_valid       (in_alloc_valid),
      .in_alloc_gpr_idx     (in_alloc_gpr_idx),
      .in_alloc_set_nzcv    (in_alloc_set_nzcv),
      .out_alloc_ready      (out_alloc_ready),
      .out_alloc_index      (out_alloc_index),
      .in_wb_valid          (in_wb_valid),
      .in_wb_rob_index      (in_wb_rob_index),
      .in_wb_value          (in_wb_value),
      .in_wb_nzcv           (in_wb_nzcv),
      .in_rd1_index         (in_rd1_index),
      .in_rd2_index         (in_rd2_index),
      .out_rd1_ready        (out_rd1_ready),
      .out_rd2_ready        (out_rd2_ready),
      .out_rd1_value        (out_rd1_value),
      .out_rd2_value        (out_rd2_value),
      .out_commit_valid     (out_commit_valid),
      .out_commit_gpr_idx   (out_commit_gpr_idx),
      .out_commit_value     (out_commit_value),
      .out_commit_set_nzcv  (out_commit_set_nzcv),
      .out_commit_nzcv      (out_commit_nzcv),
      .out_commit_rob_index (out_commit_rob_index),
      .out_count            (out_count),
      .out_wb_err           (out_wb_err)
   );

   // Clock and watchdog.
   always #5 in_clk = ~in_clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge in_clk);
      #1;
   endtask

   task automatic do_reset();
      in_rst = 1'b1;
      step();
      in_rst = 1'b0;
   endtask

   task automatic alloc(input logic [GPR_IDX_SIZE-1:0] gpr, input logic set_nz);
      in_alloc_valid    = 1'b1;
      in_alloc_gpr_idx  = gpr;
      in_alloc_set_nzcv = set_nz;
      step();
      in_alloc_valid    = 1'b0;
   endtask

   task automatic wb(input logic [ROB_IDX_SIZE-1:0] idx, input logic [REG_SIZE-1:0] val,
                     input logic [3:0] nz);
      in_wb_valid     = 1'b1;
      in_wb_rob_index = idx;
      in_wb_value     = val;
      in_wb_nzcv      = nz;
      step();
      in_wb_valid     = 1'b0;
   endtask

   task automatic push_commit(input logic [GPR_IDX_SIZE-1:0] gpr, input logic [REG_SIZE-1:0] val,
                              input logic set_nz, input logic [3:0] nz,
                              input logic [ROB_IDX_SIZE-1:0] idx);
      exp_q.push_back({gpr, val, set_nz, nz, idx});
   endtask

   task automatic check(input string name, input logic [REG_SIZE-1:0] act,
                        input logic [REG_SIZE-1:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- scoreboard monitor ----------------
   // Samples on the falling edge; every cycle with out_commit_valid is one retirement.
   always @(negedge in_clk) begin
      logic [CW-1:0] got, exp;
      if (!in_rst && out_commit_valid) begin
         got = {out_commit_gpr_idx, out_commit_value, out_commit_set_nzcv,
                out_commit_nzcv, out_commit_rob_index};
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL commit_unexpected: got 0x%0h, expected no commit", got);
         end else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin
               miscompares++;
               $display("FAIL commit: got 0x%0h, expected 0x%0h", got, exp);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      in_rst = 1'b1; in_alloc_valid = 1'b0; in_alloc_gpr_idx = '0; in_alloc_set_nzcv = 1'b0;
      in_wb_valid = 1'b0; in_wb_rob_index = '0; in_wb_value = '0; in_wb_nzcv = '0;
      in_rd1_index = '0; in_rd2_index = '0;
      step();
      step();
      in_rst = 1'b0;

      // Reset state.
      check("rst_alloc_ready", 64'(out_alloc_ready), 64'd1);
      check("rst_count", 64'(out_count), 64'd0);
      check("rst_commit_valid", 64'(out_commit_valid), 64'd0);
      check("rst_wb_err", 64'(out_wb_err), 64'd0);
      check("rst_rd1_ready", 64'(out_rd1_ready), 64'd0);

      // Out-of-order writeback, in-order commit.
      check("t2_idx0", 64'(out_alloc_index), 64'd0);
      alloc(5'd1, 1'b0);
      check("t2_idx1", 64'(out_alloc_index), 64'd1);
      alloc(5'd2, 1'b1);
      check("t2_idx2", 64'(out_alloc_index), 64'd2);
      alloc(5'd3, 1'b0);
      push_commit(5'd1, 64'h55, 1'b0, 4'h8, 5'd0);
      push_commit(5'd2, 64'hAA, 1'b1, 4'h4, 5'd1);
      wb(5'd1, 64'hAA, 4'h4);
      check("t2_no_commit", 64'(out_commit_valid), 64'd0);
      wb(5'd0, 64'h55, 4'h8);
      check("t2_commit_valid", 64'(out_commit_valid), 64'd1);
      step();
      step();
      check("t2_count", 64'(out_count), 64'd1);
      check("t2_idle_after", 64'(out_commit_valid), 64'd0);

      // Fill to full, reject the extra request, then free one and wrap the tail.
      do_reset();
      for (int i = 0; i < ROB_SIZE; i++) begin
         check("t3_alloc_idx", 64'(out_alloc_index), 64'(i));
         alloc(5'(i + 4), 1'b0);
      end
      check("t3_full_ready", 64'(out_alloc_ready), 64'd0);
      check("t3_full_count", 64'(out_count), 64'd18);
      check("t3_tail_wrap", 64'(out_alloc_index), 64'd0);
      alloc(5'd31, 1'b1);
      check("t3_ignored_count", 64'(out_count), 64'd18);
      push_commit(5'd4, 64'h100, 1'b0, 4'h0, 5'd0);
      wb(5'd0, 64'h100, 4'h0);
      check("t3_ready_during_commit", 64'(out_alloc_ready), 64'd0);
      step();
      check("t3_ready_after", 64'(out_alloc_ready), 64'd1);
      check("t3_count_after", 64'(out_count), 64'd17);
      check("t3_wrap_idx", 64'(out_alloc_index), 64'd0);
      alloc(5'd9, 1'b0);
      check("t3_refull_count", 64'(out_count), 64'd18);
      check("t3_refull_ready", 64'(out_alloc_ready), 64'd0);

      // Allocate and commit in the same cycle at count 5.
      do_reset();
      for (int i = 0; i < 5; i++) alloc(5'(10 + i), 1'b0);
      push_commit(5'd10, 64'h77, 1'b0, 4'h0, 5'd0);
      wb(5'd0, 64'h77, 4'h0);
      check("t4_commit_pending", 64'(out_commit_valid), 64'd1);
      alloc(5'd15, 1'b0);
      check("t4_count_same", 64'(out_count), 64'd5);
      check("t4_tail_adv", 64'(out_alloc_index), 64'd6);
      check("t4_head_not_done", 64'(out_commit_valid), 64'd0);
      push_commit(5'd11, 64'h88, 1'b0, 4'h0, 5'd1);
      wb(5'd1, 64'h88, 4'h0);
      step();
      check("t4_count_end", 64'(out_count), 64'd4);

      // Read-port forwarding and stored reads; writeback to a free entry.
      push_commit(5'd12, 64'h1234, 1'b0, 4'h2, 5'd2);
      in_rd1_index    = 5'd2;
      in_rd2_index    = 5'd3;
      in_wb_valid     = 1'b1;
      in_wb_rob_index = 5'd2;
      in_wb_value     = 64'h1234;
      in_wb_nzcv      = 4'h2;
      #1;
      check("t5_fwd_ready", 64'(out_rd1_ready), 64'd1);
      check("t5_fwd_value", out_rd1_value, 64'h1234);
      check("t5_rd2_ready", 64'(out_rd2_ready), 64'd0);
      check("t5_rd2_value", out_rd2_value, 64'd0);
      @(posedge in_clk);
      #1;
      in_wb_valid = 1'b0;
      check("t5_stored_ready", 64'(out_rd1_ready), 64'd1);
      check("t5_stored_value", out_rd1_value, 64'h1234);
      step();
      check("t5_retired_ready", 64'(out_rd1_ready), 64'd0);
      check("t5_retired_value", out_rd1_value, 64'd0);
      check("t5_err_clear", 64'(out_wb_err), 64'd0);
      wb(5'd9, 64'hBEEF, 4'h0);
      check("t5_err_set", 64'(out_wb_err), 64'd1);
      step();
      check("t5_err_sticky", 64'(out_wb_err), 64'd1);

      // Reset with entries in flight and a completed head: nothing retires.
      alloc(5'd20, 1'b0);
      check("t6_count_before", 64'(out_count), 64'd4);
      wb(5'd3, 64'hDEAD, 4'h1);
      in_rst = 1'b1;
      step();
      in_rst = 1'b0;
      check("t6_count", 64'(out_count), 64'd0);
      check("t6_commit_valid", 64'(out_commit_valid), 64'd0);
      check("t6_err_cleared", 64'(out_wb_err), 64'd0);
      check("t6_alloc_ready", 64'(out_alloc_ready), 64'd1);
      check("t6_alloc_index", 64'(out_alloc_index), 64'd0);
      check("t6_rd1_ready", 64'(out_rd1_ready), 64'd0);
      wb(5'd0, 64'h1, 4'h0);
      check("t6_stale_wb_err", 64'(out_wb_err), 64'd1);
      step();
      step();

      // Every expected retirement must have been observed.
      check("exp_q_drained", 64'(exp_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
